uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive-side buffer that sits directly downstream of the simpleuart receiver.
- Drains the UART's single-byte receive holding register into a DEPTH-entry FIFO, so the CPU can tolerate bursts without losing characters.
- Presents a first-word-fall-through bus read port with level, empty, full and sticky-overflow status.

Parameters:
- DEPTH, 16, number of byte entries; power of two, >= 2.
- AW, 4, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- uart_valid  input  1  UART holding register full (UART recv_buf_valid).
- uart_data  input  8  UART received byte (low byte of UART reg_dat_do).
- uart_re  output  1  one-cycle read strobe to UART (UART reg_dat_re).
- rd_req  input  1  bus pop request.
- rd_data  output  32  {24'h0, head byte} when not empty; 32'hFFFF_FFFF when empty.
- level  output  AW+1  current entry count, 0..DEPTH.
- empty  output  1  level == 0.
- full  output  1  level == DEPTH.
- overflow  output  1  sticky; a byte was dropped because the FIFO was full.
- clr_overflow  input  1  clears overflow.
- flush  input  1  synchronous empty of the FIFO.

Behaviour:
- Reset (async assert) forces the following; release takes effect on the next clk edge:
  - uart_re=0, level=0, empty=1, full=0, overflow=0.
  - Read and write pointers = 0; rd_data=32'hFFFF_FFFF.
- Storage is a DEPTH x 8 register array; contents are not reset.
- Capture condition: uart_valid && !uart_re.
  - The UART clears valid one cycle after the strobe, so valid is ignored in the cycle uart_re is high. This prevents double capture.
- On the capture condition:
  - uart_re is registered high for exactly one cycle (latency 1 from uart_valid).
  - uart_data is written at that same edge if space is available.
- Space available: !full, or full && rd_req (simultaneous pop frees a slot).
- Full with no pop: the byte is dropped, uart_re still pulses (UART is drained), and overflow is set.
- Pop: rd_req && !empty advances the read pointer at the edge; rd_data shows the next head on the following cycle.
  - rd_req when empty is ignored; no pointer or level change.
- Simultaneous push and pop: level unchanged and both pointers advance.
  - At level 0 only the push takes effect, because the pop is ignored when empty.
- Pointers wrap modulo DEPTH; level is tracked as a separate AW+1-bit counter.
- Flush has priority over push and pop:
  - Pointers and level go to 0 and overflow is cleared.
  - A capture in the same cycle is discarded, but uart_re still pulses.
- Overflow priority: set beats clr_overflow in the same cycle.
- rd_data, empty, full and level are combinational from the registered state; no bus-side latency.

Optional Feature:
- Macro: UART_RX_FIFO_THRESH_IRQ_EN.
- Defined: adds the following ports:
  - thresh  input  AW+1  interrupt threshold.
  - irq  output  1  registered; high the cycle after (level >= thresh && thresh != 0) || overflow; reset value 0.
- Not defined: thresh and irq do not exist; all other behaviour is identical.

Test Plan:
- Reset then single byte: drive uart_valid=1, uart_data=8'h41 and drop valid 1 cycle after uart_re.
  - Required: uart_re high for exactly 1 cycle, level=1, rd_data=32'h0000_0041.
  - Then pulse rd_req: empty=1 and rd_data=32'hFFFF_FFFF next cycle.
- Hold uart_valid=1 through the cycle where uart_re=1.
  - Required: only one entry is written (level=1).
- Fill with 8'h00..8'h0F (DEPTH=16).
  - Required: full=1.
  - 17th byte 8'hAA: uart_re pulses, overflow=1, level=16, head still 8'h00.
  - clr_overflow: overflow=0.
- At full, push 8'h55 with rd_req in the same cycle.
  - Required: level stays 16; popping all bytes yields 8'h01..8'h0F, then 8'h55.
- Wrap: push and pop 40 bytes of an incrementing pattern at level 0..3.
  - Required: data order preserved across pointer wrap and level never exceeds 3.
- Flush at level 5 concurrent with a capture: level=0, empty=1, overflow=0, uart_re pulses once.
  - With UART_RX_FIFO_THRESH_IRQ_EN, thresh=4: irq rises the cycle after the 4th push and falls after a pop to level 3.
  - Mid-stream async reset: all outputs return to reset values immediately.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte FIFO placed behind the simpleuart receiver.
// Drains the UART's single-byte holding register into a DEPTH-entry FIFO and
// exposes a first-word-fall-through read port with level/empty/full and a
// sticky overflow flag.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   uart_valid, uart_data  UART holding register full flag and received byte
//   uart_re                one-cycle read strobe back to the UART
//   rd_req, rd_data        bus pop request, head byte (all ones when empty)
//   level, empty, full     occupancy status
//   overflow, clr_overflow sticky dropped-byte flag and its clear
//   flush                  synchronous empty of the FIFO
//   thresh, irq            threshold interrupt (only with UART_RX_FIFO_THRESH_IRQ_EN)
//
// Optional feature macro: UART_RX_FIFO_THRESH_IRQ_EN
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          uart_valid,
  input  logic [7:0]    uart_data,
  output logic          uart_re,
  input  logic          rd_req,
  output logic [31:0]   rd_data,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  input  logic          clr_overflow,
  input  logic          flush
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
  ,
  input  logic [AW:0]   thresh,
  output logic          irq
`endif
);

  localparam logic [AW:0] FullLevel = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          re_q, re_d;
  logic          capture, pop, push, drop;

  assign empty    = (level_q == '0);
  assign full     = (level_q == FullLevel);
  assign level    = level_q;
  assign overflow = ovf_q;
  assign uart_re  = re_q;
  assign rd_data  = empty ? 32'hFFFF_FFFF : {24'h0, mem_q[rptr_q]};

  always_comb begin
    // valid is stale in the strobe cycle: the UART only clears it one cycle later
    capture = uart_valid && !re_q;
    pop     = rd_req && !empty;
    // a pop at full frees the slot the incoming byte needs
    push    = capture && (!full || rd_req);
    drop    = capture && full && !rd_req;
    re_d    = capture;

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q;

    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
      if (drop) begin
        ovf_d = 1'b1;
      end else if (clr_overflow) begin
        ovf_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      re_q    <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      re_q    <= re_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wptr_q] <= uart_data;
    end
  end

`ifdef UART_RX_FIFO_THRESH_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = ((level_q >= thresh) && (thresh != '0)) || ovf_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a queue-based reference model updated
// on each clock edge, and a monitor that compares DUT outputs mid-cycle and
// pops expected bytes whenever the DUT performs a read.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          uart_valid = 1'b0;
  logic [7:0]    uart_data = 8'h00;
  logic          uart_re;
  logic          rd_req = 1'b0;
  logic [31:0]   rd_data;
  logic [AW:0]   level;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          clr_overflow = 1'b0;
  logic          flush = 1'b0;
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
  logic [AW:0]   thresh = 5'd4;
  logic          irq;
`endif

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .uart_valid   (uart_valid),
    .uart_data    (uart_data),
    .uart_re      (uart_re),
    .rd_req       (rd_req),
    .rd_data      (rd_data),
    .level        (level),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .flush        (flush)
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
    ,
    .thresh       (thresh),
    .irq          (irq)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: byte queue plus occupancy and flag state.
  logic [7:0] sb_q[$];
  int         m_level = 0;
  bit         m_ovf   = 0;
  bit         m_re    = 0;
  bit         m_irq   = 0;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        sb_q.delete();
        m_level = 0;
        m_ovf   = 0;
        m_re    = 0;
        m_irq   = 0;
      end else begin
        bit cap, pops, room;
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
        m_irq = ((m_level >= int'(thresh)) && (thresh != 0)) || m_ovf;
`endif
        cap  = uart_valid && !m_re;
        pops = rd_req && (m_level > 0);
        room = (m_level < DEPTH) || rd_req;
        if (flush) begin
          sb_q.delete();
          m_level = 0;
          m_ovf   = 0;
        end else begin
          if (cap && room) begin
            sb_q.push_back(uart_data);
            m_level++;
          end
          if (pops) m_level--;
          if (cap && !room) m_ovf = 1;
          else if (clr_overflow) m_ovf = 0;
        end
        m_re = cap;
      end
    end
  end

  // Monitor: compare mid-cycle, consume expected bytes on each DUT pop.
  initial begin
    forever begin
      logic [31:0] exp_rd;
      @(negedge clk);
      chk("uart_re", 32'(uart_re), 32'(m_re));
      chk("level", 32'(level), 32'(m_level));
      chk("empty", 32'(empty), 32'(m_level == 0));
      chk("full", 32'(full), 32'(m_level == DEPTH));
      chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
      chk("irq", 32'(irq), 32'(m_irq));
`endif
      exp_rd = (sb_q.size() == 0) ? 32'hFFFF_FFFF : {24'h0, sb_q[0]};
      chk("rd_data", rd_data, exp_rd);
      if (rd_req && !empty && !reset) begin
        if (sb_q.size() == 0) begin
          chk("pop_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
          chk("pop_data", 32'(rd_data[7:0]), 32'(sb_q[0]));
          void'(sb_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // UART-like sender: hold valid until the strobe, drop it one cycle later.
  task automatic send_byte(input logic [7:0] b, input bit with_pop, input bit with_flush);
    bit got = 0;
    uart_data  = b;
    uart_valid = 1'b1;
    if (with_pop)   rd_req = 1'b1;
    if (with_flush) flush  = 1'b1;
    for (int n = 0; n < 10 && !got; n++) begin
      tick();
      if (with_pop)   rd_req = 1'b0;
      if (with_flush) flush  = 1'b0;
      if (uart_re) got = 1;
    end
    chk("uart_re_seen", 32'(got), 32'd1);
    tick();
    uart_valid = 1'b0;
  endtask

  task automatic pop_one();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  initial begin
    int max_lvl;
    bit done;

    repeat (3) tick();
    chk("reset_rd_data", rd_data, 32'hFFFF_FFFF);
    chk("reset_empty", 32'(empty), 32'd1);
    reset = 1'b0;
    tick();

    // Single byte, then pop it.
    send_byte(8'h41, 0, 0);
    tick();
    chk("single_level", 32'(level), 32'd1);
    chk("single_rd_data", rd_data, 32'h0000_0041);
    pop_one();
    chk("single_pop_empty", 32'(empty), 32'd1);
    chk("single_pop_rd_data", rd_data, 32'hFFFF_FFFF);

    // Fill, then overflow.
    for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 0, 0);
    tick();
    chk("fill_full", 32'(full), 32'd1);
    send_byte(8'hAA, 0, 0);
    tick();
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(level), 32'd16);
    chk("ovf_head", rd_data, 32'h0000_0000);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Push and pop together at full.
    send_byte(8'h55, 1, 0);
    tick();
    chk("fullpp_level", 32'(level), 32'd16);
    for (int i = 1; i < DEPTH; i++) begin
      chk("fullpp_order", 32'(rd_data[7:0]), 32'(i));
      pop_one();
    end
    chk("fullpp_last", rd_data, 32'h0000_0055);
    pop_one();
    chk("fullpp_empty", 32'(empty), 32'd1);

    // Wrap: low occupancy across several pointer laps.
    max_lvl = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_level >= 3) pop_one();
      send_byte(8'(8'h20 + i), 0, 0);
      if (int'(level) > max_lvl) max_lvl = int'(level);
      if ($urandom_range(0, 1) == 1) pop_one();
    end
    chk("wrap_max_level_le3", 32'(max_lvl <= 3), 32'd1);
    while (m_level > 0) pop_one();
    tick();

    // Flush at level 5 concurrent with a capture.
    for (int i = 0; i < 5; i++) begin
      send_byte(8'(8'h70 + i), 0, 0);
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
      tick();
      chk("irq_thresh", 32'(irq), 32'(i >= 3));
`endif
    end
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
    pop_one();
    pop_one();
    tick();
    chk("irq_fall", 32'(irq), 32'd0);
    send_byte(8'h75, 0, 0);
    send_byte(8'h76, 0, 0);
`endif
    chk("pre_flush_level", 32'(level), 32'd5);
    send_byte(8'h99, 0, 1);
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_ovf", 32'(overflow), 32'd0);
    tick();

    // Random traffic.
    done = 0;
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          send_byte(8'($urandom), 0, 0);
        end
        done = 1;
      end
      begin
        while (!done) begin
          tick();
          rd_req       = ($urandom_range(0, 9) < 2);
          clr_overflow = ($urandom_range(0, 19) == 0);
          flush        = ($urandom_range(0, 79) == 0);
        end
        rd_req       = 1'b0;
        clr_overflow = 1'b0;
        flush        = 1'b0;
      end
    join
    tick();

    // Mid-stream asynchronous reset while a strobe is in flight.
    while (m_level < 3) send_byte(8'($urandom), 0, 0);
    uart_data  = 8'hC3;
    uart_valid = 1'b1;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_uart_re", 32'(uart_re), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    chk("arst_rd_data", rd_data, 32'hFFFF_FFFF);
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
    chk("arst_irq", 32'(irq), 32'd0);
`endif
    uart_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();
    send_byte(8'h5A, 0, 0);
    tick();
    chk("post_reset_data", rd_data, 32'h0000_005A);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
